// File: rtl/kernel_ram.sv
// kernel_ram: one evaluation unit for a Zhang-Suen style thinning pass.
// It captures a 3x3 binary neighbourhood around pixel IDENTIFIER from a
// streamed row-major N*N image. On each evaluate strobe it registers
// 8'hFF (keep) or 8'h00 (background/deleted).
// Optional feature: define KERNEL_RAM_SUBITER_EN to add the `phase` input,
// which selects the second sub-iteration product terms.
module kernel_ram #(
    parameter int N          = 8,
    parameter int BIT_SIZE   = 6,
    parameter int IDENTIFIER = 0,
    parameter int PADDED     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [BIT_SIZE:0] address,
    input  logic [7:0]        data_in,
`ifdef KERNEL_RAM_SUBITER_EN
    input  logic              phase,
`endif
    output logic [7:0]        data_out
);

    localparam int NPIX = N * N;
    localparam int ROW  = IDENTIFIER / N;
    localparam int COL  = IDENTIFIER % N;

    if (PADDED != 0) begin : g_pad
        // A padding unit has no neighbourhood; every input is deliberately unused.
        logic unused_pad;
`ifdef KERNEL_RAM_SUBITER_EN
        assign unused_pad = ^{clk, rst_n, we, re, address, data_in, phase};
`else
        assign unused_pad = ^{clk, rst_n, we, re, address, data_in};
`endif
        assign data_out = 8'h00;
    end else begin : g_unit
        if (ROW == 0 || ROW == N - 1 || COL == 0 || COL == N - 1 || IDENTIFIER >= NPIX) begin : g_bad_id
            $error("kernel_ram: IDENTIFIER %0d lies on the image border", IDENTIFIER);
        end

        // Linear index of P1..P9 (element k holds P(k+1)).
        localparam int NIDX [9] = '{
            IDENTIFIER,         IDENTIFIER - N,     IDENTIFIER - N + 1,
            IDENTIFIER + 1,     IDENTIFIER + N + 1, IDENTIFIER + N,
            IDENTIFIER + N - 1, IDENTIFIER - 1,     IDENTIFIER - N - 1
        };

        logic [8:0] p_q;      // bit k = P(k+1)
        logic [7:0] dout_q;
        logic [7:0] dout_d;
        logic [7:0] ring;     // P2..P9 in clockwise order
        logic [3:0] b_cnt;
        logic [3:0] a_cnt;
        logic       prod_ok;
        logic       del;
        int         addr_i;

        assign addr_i = int'({{(31 - BIT_SIZE){1'b0}}, address});
        assign ring   = p_q[8:1];

        // Neighbour counting and the delete decision on the pre-edge pixels.
        always_comb begin
            b_cnt = '0;
            a_cnt = '0;
            for (int i = 0; i < 8; i++) begin
                b_cnt = b_cnt + {3'b000, ring[i]};
                if (!ring[i] && ring[(i + 1) % 8]) a_cnt = a_cnt + 4'd1;
            end
`ifdef KERNEL_RAM_SUBITER_EN
            if (phase)
                prod_ok = ~(p_q[1] & p_q[3] & p_q[7]) & ~(p_q[1] & p_q[5] & p_q[7]);
            else
                prod_ok = ~(p_q[1] & p_q[3] & p_q[5]) & ~(p_q[3] & p_q[5] & p_q[7]);
`else
            prod_ok = ~(p_q[1] & p_q[3] & p_q[5]) & ~(p_q[3] & p_q[5] & p_q[7]);
`endif
            del    = p_q[0] & (b_cnt >= 4'd2) & (b_cnt <= 4'd6) & (a_cnt == 4'd1) & prod_ok;
            dout_d = (p_q[0] & ~del) ? 8'hFF : 8'h00;
        end

        // Capture pixels addressed by a write; out-of-image neighbours never load.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                p_q <= '0;
            end else if (we && addr_i < NPIX) begin
                for (int k = 0; k < 9; k++) begin
                    if (NIDX[k] >= 0 && NIDX[k] < NPIX && addr_i == NIDX[k])
                        p_q[k] <= (data_in != 8'h00);
                end
            end
        end

        // Register the verdict on evaluate; hold otherwise.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)  dout_q <= 8'h00;
            else if (re) dout_q <= dout_d;
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_kernel_ram.sv
// Directed bench for kernel_ram (N=8, IDENTIFIER=27) plus a padding unit.
// Expected verdicts are queued when the evaluate strobe is driven and
// popped when data_out is sampled one edge later.
module tb_kernel_ram;

    localparam int N  = 8;
    localparam int BS = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic        re;
    logic [BS:0] address;
    logic [7:0]  data_in;
    logic        phase;
    logic [7:0]  data_out;
    logic [7:0]  data_out_pad;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [7:0] exp_q [$];
    string      tag_q [$];

    always #5 clk = ~clk;

    kernel_ram #(.N(N), .BIT_SIZE(BS), .IDENTIFIER(27), .PADDED(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .we(we), .re(re), .address(address),
        .data_in(data_in),
`ifdef KERNEL_RAM_SUBITER_EN
        .phase(phase),
`endif
        .data_out(data_out)
    );

    kernel_ram #(.N(N), .BIT_SIZE(BS), .IDENTIFIER(0), .PADDED(1)) u_pad (
        .clk(clk), .rst_n(rst_n), .we(we), .re(re), .address(address),
        .data_in(data_in),
`ifdef KERNEL_RAM_SUBITER_EN
        .phase(phase),
`endif
        .data_out(data_out_pad)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        chk_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Stream a whole image; odd addresses use 01 to cover "nonzero = foreground".
    task automatic load_image(input logic [63:0] mask);
        for (int a = 0; a < N * N; a++) begin
            @(negedge clk);
            we      = 1'b1;
            address = a[BS:0];
            data_in = mask[a] ? (a[0] ? 8'h01 : 8'hFF) : 8'h00;
        end
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic evaluate(input string tag, input logic ph, input logic [7:0] expv);
        @(negedge clk);
        re    = 1'b1;
        phase = ph;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        re = 1'b0;
        check(tag_q.pop_front(), data_out, exp_q.pop_front());
        check({tag, "_pad"}, data_out_pad, 8'h00);
    endtask

    function automatic logic [63:0] bit_at(input int idx);
        logic [63:0] one;
        one = 64'd1;
        return one << idx;
    endfunction

    initial begin
        rst_n = 1'b0; we = 1'b0; re = 1'b0; address = '0; data_in = '0; phase = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dout", data_out, 8'h00);
        check("reset_pad", data_out_pad, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Isolated pixel: B=0 -> keep
        load_image(bit_at(27));
        evaluate("isolated", 1'b0, 8'hFF);

        // Output holds while re=0
        repeat (3) @(posedge clk);
        #1;
        check("hold", data_out, 8'hFF);

        // Asynchronous reset mid-cycle clears output and pixels
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", data_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        evaluate("rst_eval", 1'b0, 8'h00);

        // 2x2 block corner: B=3, A=1 -> deleted
        load_image(bit_at(27) | bit_at(28) | bit_at(35) | bit_at(36));
        evaluate("corner2x2", 1'b0, 8'h00);

        // End point: B=1 -> keep
        load_image(bit_at(27) | bit_at(28));
        evaluate("b_eq_1", 1'b0, 8'hFF);

        // Bridge: A=2 -> keep
        load_image(bit_at(27) | bit_at(19) | bit_at(35));
        evaluate("a_eq_2", 1'b0, 8'hFF);

        // B=6, A=1, P4=0 -> deleted (upper B bound inclusive)
        load_image(bit_at(27) | bit_at(36) | bit_at(35) | bit_at(34) | bit_at(26) | bit_at(18) | bit_at(19));
        evaluate("b_eq_6", 1'b0, 8'h00);

        // B=7 -> keep
        load_image(bit_at(27) | bit_at(19) | bit_at(20) | bit_at(28) | bit_at(36) | bit_at(35) | bit_at(34) | bit_at(26));
        evaluate("b_eq_7", 1'b0, 8'hFF);

        // Phase select: B=5, A=1
        load_image(bit_at(19) | bit_at(20) | bit_at(27) | bit_at(28) | bit_at(35) | bit_at(36));
        evaluate("phase0", 1'b0, 8'hFF);
`ifdef KERNEL_RAM_SUBITER_EN
        evaluate("phase1", 1'b1, 8'h00);
`endif

        // Same-edge write/evaluate: evaluation sees the old pixel
        load_image(bit_at(27));
        @(negedge clk);
        we = 1'b1; address = 7'd27; data_in = 8'h00; re = 1'b1; phase = 1'b0;
        exp_q.push_back(8'hFF);
        tag_q.push_back("wr_rd_same");
        @(posedge clk);
        #1;
        we = 1'b0; re = 1'b0;
        check(tag_q.pop_front(), data_out, exp_q.pop_front());
        evaluate("wr_rd_after", 1'b0, 8'h00);

        // Out-of-range write must not alias onto pixel 36 (100 mod 64)
        load_image(bit_at(27) | bit_at(28) | bit_at(35));
        evaluate("oob_base", 1'b0, 8'hFF);
        @(negedge clk);
        we = 1'b1; address = 7'd100; data_in = 8'hFF;
        @(negedge clk);
        we = 1'b0;
        evaluate("oob_write", 1'b0, 8'hFF);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
